// File: rtl/mmu_pkg.sv
// ----------------------------------------------------------------------------
// mmu_pkg
// Shared definitions for the 68000 page translator: function-code encodings,
// fixed physical bases of the kernel and graphics regions, the supervisor
// region classification and a couple of small decode helpers.
// Used by mmu (top) and mmu_super_map.
// ----------------------------------------------------------------------------
package mmu_pkg;

    // 68000 function codes. 000 and 100 are undefined on the CPU and are
    // treated as illegal accesses when fault detection is built in.
    typedef enum logic [2:0] {
        FC_UNDEF_USER  = 3'b000,
        FC_USER_DATA   = 3'b001,
        FC_USER_PROG   = 3'b010,
        FC_USER_RSVD   = 3'b011,
        FC_UNDEF_SUPER = 3'b100,
        FC_SUPER_DATA  = 3'b101,
        FC_SUPER_PROG  = 3'b110,
        FC_CPU         = 3'b111
    } fc_e;

    // Physical page-number prefixes of the fixed supervisor regions.
    localparam logic [5:0] KRAM_BASE = 6'b100000;
    localparam logic [5:0] KROM_BASE = 6'b010000;
    localparam logic [3:0] GFX_BASE  = 4'h3;

    // Supervisor address regions, chosen by logical address bits [23:20].
    typedef enum logic [2:0] {
        REG_KRAM,
        REG_KROM,
        REG_WIN1,
        REG_WIN2,
        REG_RSVD,
        REG_GFX
    } region_e;

    // Classify the top nibble of the logical page number.
    function automatic region_e regionOf(input logic [3:0] topNibble);
        case (topNibble)
            4'h0, 4'h1, 4'h2, 4'h3: return REG_KRAM;
            4'h4, 4'h5, 4'h6, 4'h7: return REG_KROM;
            4'h8:                   return REG_WIN1;
            4'h9:                   return REG_WIN2;
            4'hA, 4'hB:             return REG_RSVD;
            default:                return REG_GFX;
        endcase
    endfunction

    // Function codes the CPU never issues for a legal access.
    function automatic logic isIllegalFc(input logic [2:0] fc);
        return (fc == FC_UNDEF_USER) || (fc == FC_UNDEF_SUPER);
    endfunction

endpackage

// File: rtl/mmu_super_map.sv
// ----------------------------------------------------------------------------
// mmu_super_map
// Pure combinational supervisor-mode decode: fixed kernel RAM/ROM map, two
// relocatable 1 MiB windows and a straight-through graphics/audio area.
// Ports:
//   addr_i      logical page number (logical address bits [23:12])
//   map1_i      physical 1 MiB frame for window 1 (pages 0x800-0x8FF)
//   map2_i      physical 1 MiB frame for window 2 (pages 0x900-0x9FF)
//   addr_o      physical page number (physical address bits [27:12])
//   reserved_o  1 when the page lies in the reserved area 0xA00-0xBFF
// ----------------------------------------------------------------------------
module mmu_super_map
    import mmu_pkg::*;
(
    input  logic [11:0] addr_i,
    input  logic [7:0]  map1_i,
    input  logic [7:0]  map2_i,
    output logic [15:0] addr_o,
    output logic        reserved_o
);

    // Region select on the top nibble of the page number. Reserved pages are
    // still translated like the graphics area so the bus always carries a
    // defined address; the flag only feeds fault detection.
    always_comb begin
        addr_o     = {GFX_BASE, addr_i};
        reserved_o = 1'b0;
        case (regionOf(addr_i[11:8]))
            REG_KRAM: addr_o = {KRAM_BASE, addr_i[9:0]};
            REG_KROM: addr_o = {KROM_BASE, addr_i[9:0]};
            REG_WIN1: addr_o = {map1_i, addr_i[7:0]};
            REG_WIN2: addr_o = {map2_i, addr_i[7:0]};
            REG_RSVD: reserved_o = 1'b1;
            default:  addr_o = {GFX_BASE, addr_i};
        endcase
    end

endmodule

// File: rtl/mmu.sv
// ----------------------------------------------------------------------------
// mmu
// Page-granular (4 KiB) translator between the 68000 CPU bus (24-bit logical)
// and the 28-bit physical bus. User accesses go through an external
// page-table RAM indexed by {task id, page}; supervisor accesses use the
// fixed map in mmu_super_map. The datapath is purely combinational.
// Ports:
//   clk                 system clock (fault latch only)
//   reset               async active-high reset (fault latch only)
//   enable              address strobe qualifier, 1 = translate
//   addr_in             logical page number, bits [23:12]
//   fc                  68000 function code
//   user_map            current user task id, page-table bank select
//   supervisor_map_1    physical 1 MiB frame for window 1
//   supervisor_map_2    physical 1 MiB frame for window 2
//   table_ram_addr_bus  page-table RAM address, tri-state
//   table_ram_data_bus  page-table RAM read data (physical page)
//   addr_out            physical page number, bits [27:12], tri-state
//   fault               combinational fault for the current access
//   fault_latched       sticky registered fault flag
// Configuration:
//   MMU_FAULT_EN  when defined, illegal function codes (000/100) and
//                 supervisor accesses to the reserved area raise fault, and
//                 fault_latched records it until reset. When undefined both
//                 fault outputs are constant 0 and no flop exists.
// ----------------------------------------------------------------------------
module mmu
    import mmu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] addr_in,
    input  logic [2:0]  fc,
    input  logic [3:0]  user_map,
    input  logic [7:0]  supervisor_map_1,
    input  logic [7:0]  supervisor_map_2,
    output logic [15:0] table_ram_addr_bus,
    input  logic [15:0] table_ram_data_bus,
    output logic [15:0] addr_out,
    output logic        fault,
    output logic        fault_latched
);

    logic        userMode;
    logic        superMode;
    logic [15:0] superAddr;
    logic        superReserved;
    logic [15:0] physPage;

    mmu_super_map uSuperMap (
        .addr_i     (addr_in),
        .map1_i     (supervisor_map_1),
        .map2_i     (supervisor_map_2),
        .addr_o     (superAddr),
        .reserved_o (superReserved)
    );

    // CPU space (interrupt acknowledge and friends) is neither user nor
    // supervisor memory, so both buses float for it.
    always_comb begin
        userMode  = ~fc[2];
        superMode = fc[2] && (fc != FC_CPU);
        physPage  = userMode ? table_ram_data_bus : superAddr;
    end

    // The page-table RAM is only addressed by user accesses; the physical
    // bus is released whenever there is nothing to translate.
    assign table_ram_addr_bus = (enable && userMode) ? {user_map, addr_in} : 16'hzzzz;
    assign addr_out = (enable && (userMode || superMode)) ? physPage : 16'hzzzz;

`ifdef MMU_FAULT_EN
    logic faultLatched_q;
    logic faultLatched_d;

    // Illegal function codes fault in either mode; the reserved area only
    // faults for supervisor accesses since user pages never reach that decode.
    assign fault = enable && (isIllegalFc(fc) || (superMode && superReserved));

    // Sticky flag: once set, only reset clears it.
    always_comb begin
        faultLatched_d = faultLatched_q | fault;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            faultLatched_q <= 1'b0;
        end else begin
            faultLatched_q <= faultLatched_d;
        end
    end

    assign fault_latched = faultLatched_q;
`else
    logic unusedFaultInputs;

    // Without fault detection the clock, reset and reserved flag have no load.
    assign unusedFaultInputs = ^{clk, reset, superReserved};
    assign fault             = 1'b0;
    assign fault_latched     = 1'b0;
`endif

endmodule

// File: tb/tb_mmu.sv
// ----------------------------------------------------------------------------
// tb_mmu
// Self-checking bench for mmu: a table of directed vectors, randomized
// accesses checked against an arithmetic reference model, and a hand-written
// fault-latch sequence. The two tri-state buses land on pulled-up nets, so a
// released bus reads as 16'hFFFF.
// ----------------------------------------------------------------------------
module tb_mmu;

`ifdef MMU_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    localparam logic [15:0] FLOAT = 16'hFFFF;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [11:0] addrIn;
    logic [2:0]  fc;
    logic [3:0]  userMap;
    logic [7:0]  superMap1;
    logic [7:0]  superMap2;
    logic [15:0] tableData;
    tri1  [15:0] tableAddrBus;
    tri1  [15:0] addrOutBus;
    logic        fault;
    logic        faultLatched;

    int testsRun  = 0;
    int testsFail = 0;

    typedef struct {
        logic        en;
        logic [2:0]  fc;
        logic [11:0] addr;
        logic [3:0]  umap;
        logic [7:0]  m1;
        logic [7:0]  m2;
        logic [15:0] data;
        logic [15:0] expTab;
        logic [15:0] expOut;
    } vec_t;

    vec_t vecs[$];

    mmu dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .addr_in            (addrIn),
        .fc                 (fc),
        .user_map           (userMap),
        .supervisor_map_1   (superMap1),
        .supervisor_map_2   (superMap2),
        .table_ram_addr_bus (tableAddrBus),
        .table_ram_data_bus (tableData),
        .addr_out           (addrOutBus),
        .fault              (fault),
        .fault_latched      (faultLatched)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: works on page numbers as plain integers, using the
    // memory map's region bounds and offsets rather than bit fields.
    function automatic void model(input logic en, input logic [2:0] f, input logic [11:0] a,
                                  input logic [3:0] um, input logic [7:0] w1, input logic [7:0] w2,
                                  input logic [15:0] d, output logic [15:0] tab,
                                  output logic [15:0] out, output logic flt);
        int page;
        int res;
        page = int'(a);
        tab  = FLOAT;
        out  = FLOAT;
        flt  = 1'b0;
        if (en && f != 3'b111) begin
            if (f < 3'd4) begin
                tab = 16'(int'(um) * 4096 + page);
                out = d;
            end else begin
                if (page < 'h400)      res = 'h8000 + page;
                else if (page < 'h800) res = 'h4000 + (page - 'h400);
                else if (page < 'h900) res = int'(w1) * 256 + (page - 'h800);
                else if (page < 'hA00) res = int'(w2) * 256 + (page - 'h900);
                else                   res = 'h3000 + page;
                out = 16'(res);
            end
            flt = FAULT_EN && (f == 3'd0 || f == 3'd4 ||
                               (f >= 3'd4 && page >= 'hA00 && page < 'hC00));
        end
    endfunction

    // Drive one complete access onto the inputs and let it settle.
    task automatic applyStimulus(input logic en, input logic [2:0] f, input logic [11:0] a,
                                 input logic [3:0] um, input logic [7:0] w1,
                                 input logic [7:0] w2, input logic [15:0] d);
        enable    = en;
        fc        = f;
        addrIn    = a;
        userMap   = um;
        superMap1 = w1;
        superMap2 = w2;
        tableData = d;
        #1;
    endtask

    // One comparison; reports and counts a mismatch.
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Compare all three combinational outputs against the model.
    task automatic checkAccess(input string tag);
        logic [15:0] mTab;
        logic [15:0] mOut;
        logic        mFlt;
        model(enable, fc, addrIn, userMap, superMap1, superMap2, tableData, mTab, mOut, mFlt);
        checkOutput({tag, " table_addr"}, tableAddrBus, mTab);
        checkOutput({tag, " addr_out"}, addrOutBus, mOut);
        checkOutput({tag, " fault"}, {15'd0, fault}, {15'd0, mFlt});
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 3'b001, 12'h000, 4'h0, 8'h00, 8'h00, 16'h0000);

        // Reset state of the sticky flag.
        #10;
        checkOutput("reset fault_latched", {15'd0, faultLatched}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors: user translation and lookup, fixed supervisor
        // map, window relocation, region boundaries and released buses.
        vecs.push_back('{1'b1, 3'b001, 12'h000, 4'h0, 8'h00, 8'h00, 16'h0002, 16'h0000, 16'h0002});
        vecs.push_back('{1'b1, 3'b001, 12'h000, 4'h1, 8'h00, 8'h00, 16'h1234, 16'h1000, 16'h1234});
        vecs.push_back('{1'b1, 3'b010, 12'h002, 4'h0, 8'h00, 8'h00, 16'hBEEF, 16'h0002, 16'hBEEF});
        vecs.push_back('{1'b1, 3'b001, 12'h002, 4'h1, 8'h00, 8'h00, 16'h0F00, 16'h1002, 16'h0F00});
        vecs.push_back('{1'b1, 3'b010, 12'h002, 4'h4, 8'h00, 8'h00, 16'h7777, 16'h4002, 16'h7777});
        vecs.push_back('{1'b1, 3'b101, 12'h000, 4'h0, 8'h00, 8'h00, 16'h1111, FLOAT,    16'h8000});
        vecs.push_back('{1'b1, 3'b101, 12'h3FF, 4'h0, 8'h00, 8'h00, 16'h1111, FLOAT,    16'h83FF});
        vecs.push_back('{1'b1, 3'b101, 12'h400, 4'h0, 8'h00, 8'h00, 16'h1111, FLOAT,    16'h4000});
        vecs.push_back('{1'b1, 3'b110, 12'h7FF, 4'h0, 8'h00, 8'h00, 16'h1111, FLOAT,    16'h43FF});
        vecs.push_back('{1'b1, 3'b101, 12'h800, 4'h0, 8'hA5, 8'h3C, 16'h1111, FLOAT,    16'hA500});
        vecs.push_back('{1'b1, 3'b101, 12'h812, 4'h0, 8'hA5, 8'h3C, 16'h1111, FLOAT,    16'hA512});
        vecs.push_back('{1'b1, 3'b101, 12'h8FF, 4'h0, 8'hA5, 8'h3C, 16'h1111, FLOAT,    16'hA5FF});
        vecs.push_back('{1'b1, 3'b110, 12'h900, 4'h0, 8'hA5, 8'h3C, 16'h1111, FLOAT,    16'h3C00});
        vecs.push_back('{1'b1, 3'b101, 12'h9FF, 4'h0, 8'hA5, 8'h3C, 16'h1111, FLOAT,    16'h3CFF});
        vecs.push_back('{1'b1, 3'b101, 12'hA00, 4'h0, 8'hA5, 8'h3C, 16'h1111, FLOAT,    16'h3A00});
        vecs.push_back('{1'b1, 3'b101, 12'hBFF, 4'h0, 8'hA5, 8'h3C, 16'h1111, FLOAT,    16'h3BFF});
        vecs.push_back('{1'b1, 3'b101, 12'hC00, 4'h0, 8'h00, 8'h00, 16'h1111, FLOAT,    16'h3C00});
        vecs.push_back('{1'b1, 3'b101, 12'hF0E, 4'h0, 8'h00, 8'h00, 16'h1111, FLOAT,    16'h3F0E});
        vecs.push_back('{1'b1, 3'b101, 12'hFFF, 4'h0, 8'h00, 8'h00, 16'h1111, FLOAT,    16'h3FFF});
        vecs.push_back('{1'b0, 3'b001, 12'h123, 4'h2, 8'h00, 8'h00, 16'h5555, FLOAT,    FLOAT});
        vecs.push_back('{1'b0, 3'b101, 12'h123, 4'h2, 8'h00, 8'h00, 16'h5555, FLOAT,    FLOAT});
        vecs.push_back('{1'b1, 3'b111, 12'h123, 4'h2, 8'h00, 8'h00, 16'h5555, FLOAT,    FLOAT});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].fc, vecs[i].addr, vecs[i].umap,
                          vecs[i].m1, vecs[i].m2, vecs[i].data);
            checkOutput($sformatf("vec%0d table_addr", i), tableAddrBus, vecs[i].expTab);
            checkOutput($sformatf("vec%0d addr_out", i), addrOutBus, vecs[i].expOut);
        end

        // Randomized accesses against the reference model, including fault.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                          12'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                          16'($urandom));
            checkAccess($sformatf("rand%0d", n));
        end

        // Fault latch: clear, confirm it stays clear on a legal access,
        // set it with a reserved-area supervisor access, hold, then reset.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        applyStimulus(1'b1, 3'b101, 12'h123, 4'h0, 8'h00, 8'h00, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("latch clear after legal", {15'd0, faultLatched}, 16'h0000);

        applyStimulus(1'b1, 3'b101, 12'hA00, 4'h0, 8'h00, 8'h00, 16'h0000);
        checkOutput("reserved fault", {15'd0, fault}, {15'd0, FAULT_EN});
        checkOutput("reserved addr_out", addrOutBus, 16'h3A00);
        checkOutput("latch before edge", {15'd0, faultLatched}, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("latch set", {15'd0, faultLatched}, {15'd0, FAULT_EN});

        applyStimulus(1'b1, 3'b001, 12'h010, 4'h0, 8'h00, 8'h00, 16'h0042);
        checkOutput("fault gone", {15'd0, fault}, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("latch held", {15'd0, faultLatched}, {15'd0, FAULT_EN});

        reset = 1'b1;
        #2;
        checkOutput("latch reset", {15'd0, faultLatched}, 16'h0000);
        reset = 1'b0;

        // Undefined function code in user space.
        applyStimulus(1'b1, 3'b000, 12'h010, 4'h0, 8'h00, 8'h00, 16'h0042);
        checkOutput("fc000 fault", {15'd0, fault}, {15'd0, FAULT_EN});
        checkOutput("fc000 addr_out", addrOutBus, 16'h0042);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
